// File: rtl/noc_pkg.sv
// Shared definitions for the node network interface.
// Holds the flit width, flit type codes, header field positions, the TX
// state encoding and two helpers that assemble flits and header payloads.
// Flit layout: [16] valid, [15:14] type, [13:0] payload.
// Header payload: [13:10] dest, [9:6] src, [5:3] body count, [2:0] zero.
package noc_pkg;

    localparam int FLIT_W    = 17;
    localparam int PAYLOAD_W = 14;

    localparam int VALID_BIT = 16;
    localparam int TYPE_HI   = 15;
    localparam int TYPE_LO   = 14;
    localparam int DEST_HI   = 13;
    localparam int DEST_LO   = 10;
    localparam int SRC_HI    = 9;
    localparam int SRC_LO    = 6;
    localparam int CNT_HI    = 5;
    localparam int CNT_LO    = 3;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } tx_state_t;

    function automatic logic [FLIT_W-1:0] make_flit(input logic [1:0] flit_type,
                                                    input logic [PAYLOAD_W-1:0] payload);
        return {1'b1, flit_type, payload};
    endfunction

    function automatic logic [PAYLOAD_W-1:0] head_payload(input logic [3:0] dest,
                                                          input logic [3:0] src,
                                                          input logic [2:0] cnt);
        return {dest, src, cnt, 3'b000};
    endfunction

endpackage

// File: rtl/network_interface_if.sv
// Bundle of the core-side and router-side signals of one network interface.
// Core TX:  tx_req_i/tx_dest_i/tx_len_i -> tx_ack_o ; tx_body_valid_i/tx_body_i -> tx_body_ready_o
// Router:   router_full_i, router_data_o (to router), router_data_i (from router)
// Core RX:  rx_valid_o, rx_head_o, rx_last_o, rx_src_o, rx_data_o, rx_err_o
//
// Handshakes: a request is held until the single-cycle tx_ack_o pulse. A body
// word transfers in exactly the cycles where tx_body_valid_i and
// tx_body_ready_o are both high; ready is never high without valid. The
// receive side has no backpressure: every rx_valid_o cycle is a transfer.
interface network_interface_if;
    import noc_pkg::*;

    logic                 tx_req_i;
    logic [3:0]           tx_dest_i;
    logic [2:0]           tx_len_i;
    logic                 tx_ack_o;
    logic                 tx_body_valid_i;
    logic [PAYLOAD_W-1:0] tx_body_i;
    logic                 tx_body_ready_o;
    logic                 router_full_i;
    logic [FLIT_W-1:0]    router_data_o;
    logic [FLIT_W-1:0]    router_data_i;
    logic                 rx_valid_o;
    logic                 rx_head_o;
    logic                 rx_last_o;
    logic [3:0]           rx_src_o;
    logic [PAYLOAD_W-1:0] rx_data_o;
    logic                 rx_err_o;

    // The network interface itself.
    modport slave (
        input  tx_req_i, tx_dest_i, tx_len_i, tx_body_valid_i, tx_body_i,
               router_full_i, router_data_i,
        output tx_ack_o, tx_body_ready_o, router_data_o,
               rx_valid_o, rx_head_o, rx_last_o, rx_src_o, rx_data_o, rx_err_o
    );

    // The core and router environment around it.
    modport master (
        output tx_req_i, tx_dest_i, tx_len_i, tx_body_valid_i, tx_body_i,
               router_full_i, router_data_i,
        input  tx_ack_o, tx_body_ready_o, router_data_o,
               rx_valid_o, rx_head_o, rx_last_o, rx_src_o, rx_data_o, rx_err_o
    );

endinterface

// File: rtl/rx_depacketizer.sv
// Receive stage: registers flits from the router local output, tracks the
// open packet and raises a sticky protocol-error flag.
// Ports: clk, rst (sync, active high), flit_i (raw flit from router),
// rx_valid_o/rx_head_o/rx_last_o/rx_src_o/rx_data_o/rx_err_o (registered).
module rx_depacketizer
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    flit_i,
    output logic                 rx_valid_o,
    output logic                 rx_head_o,
    output logic                 rx_last_o,
    output logic [3:0]           rx_src_o,
    output logic [PAYLOAD_W-1:0] rx_data_o,
    output logic                 rx_err_o
);

    logic       open_q;
    logic [2:0] count_q;
    logic       is_valid, is_head, is_body, is_tail;
    logic [2:0] count_dec;
    logic       err_now, last_now;

    always_comb begin
        is_valid  = flit_i[VALID_BIT];
        is_head   = is_valid && (flit_i[TYPE_HI:TYPE_LO] == TYPE_HEAD);
        is_body   = is_valid && (flit_i[TYPE_HI:TYPE_LO] == TYPE_BODY);
        is_tail   = is_valid && (flit_i[TYPE_HI:TYPE_LO] == TYPE_TAIL);
        count_dec = count_q - 3'd1;
        err_now   = (is_head && open_q)
                  || ((is_body || is_tail) && !open_q)
                  || (is_tail && open_q && (count_q != 3'd1));
        // A body that exhausts the announced count ends the packet even
        // without a tail marker.
        last_now  = is_tail || (is_body && open_q && (count_dec == 3'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q     <= 1'b0;
            count_q    <= 3'd0;
            rx_valid_o <= 1'b0;
            rx_head_o  <= 1'b0;
            rx_last_o  <= 1'b0;
            rx_src_o   <= 4'd0;
            rx_data_o  <= '0;
            rx_err_o   <= 1'b0;
        end else begin
            rx_valid_o <= is_valid;
            rx_head_o  <= is_head;
            rx_last_o  <= last_now;
            rx_data_o  <= is_valid ? flit_i[PAYLOAD_W-1:0] : '0;
            rx_err_o   <= rx_err_o | err_now;
            if (is_head) begin
                rx_src_o <= flit_i[SRC_HI:SRC_LO];
                count_q  <= flit_i[CNT_HI:CNT_LO];
                open_q   <= 1'b1;
            end else if ((is_body || is_tail) && open_q) begin
                count_q <= count_dec;
                if (last_now) begin
                    open_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/network_interface.sv
// Per-node packetizer/depacketizer between a core and its router local port.
// TX: a core request becomes a header flit followed by body flits, one per
// cycle while the router has credit. RX: delegated to rx_depacketizer.
// Ports: clk, rst (sync, active high), nif (network_interface_if.slave),
// tx_state_o (current TX FSM state for observation).
module network_interface
    import noc_pkg::*;
#(
    parameter logic [3:0] NODE_ID = 4'd0
)
(
    input  logic               clk,
    input  logic               rst,
    network_interface_if.slave nif,
    output tx_state_t          tx_state_o
);

    tx_state_t         state_q, state_d;
    logic [3:0]        dest_q, dest_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        remain_q, remain_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              ack, body_ready;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        len_d      = len_q;
        remain_d   = remain_q;
        flit_d     = '0;
        ack        = 1'b0;
        body_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (nif.tx_req_i) begin
                    state_d = HEAD;
                    dest_d  = nif.tx_dest_i;
                    // A zero length is treated as a single-body packet.
                    len_d   = (nif.tx_len_i == 3'd0) ? 3'd1 : nif.tx_len_i;
                end
            end
            HEAD: begin
                if (!nif.router_full_i) begin
                    ack      = 1'b1;
                    flit_d   = make_flit(TYPE_HEAD, head_payload(dest_q, NODE_ID, len_q));
                    remain_d = len_q;
                    state_d  = BODY;
                end
            end
            BODY: begin
                if (nif.tx_body_valid_i && !nif.router_full_i) begin
                    body_ready = 1'b1;
                    flit_d     = make_flit((remain_q == 3'd1) ? TYPE_TAIL : TYPE_BODY,
                                           nif.tx_body_i);
                    remain_d   = remain_q - 3'd1;
                    if (remain_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dest_q   <= 4'd0;
            len_q    <= 3'd0;
            remain_q <= 3'd0;
            flit_q   <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            flit_q   <= flit_d;
        end
    end

    assign nif.tx_ack_o        = ack;
    assign nif.tx_body_ready_o = body_ready;
    assign nif.router_data_o   = flit_q;
    assign tx_state_o          = state_q;

    rx_depacketizer u_rx (
        .clk        (clk),
        .rst        (rst),
        .flit_i     (nif.router_data_i),
        .rx_valid_o (nif.rx_valid_o),
        .rx_head_o  (nif.rx_head_o),
        .rx_last_o  (nif.rx_last_o),
        .rx_src_o   (nif.rx_src_o),
        .rx_data_o  (nif.rx_data_o),
        .rx_err_o   (nif.rx_err_o)
    );

endmodule

// File: tb/tb_network_interface.sv
module tb_network_interface;
  import noc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  network_interface_if nif();
  tx_state_t tx_state;

  network_interface #(.NODE_ID(4'd2)) dut (
    .clk        (clk),
    .rst        (rst),
    .nif        (nif.slave),
    .tx_state_o (tx_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0] dest;
    logic [2:0] len;
  } req_t;

  typedef struct packed {
    logic        valid;
    logic        head;
    logic        last;
    logic [3:0]  src;
    logic [13:0] data;
    logic        err;
  } rx_exp_t;

  logic [16:0] exp_q[$];     // expected flits toward the router, in order
  logic [13:0] words_q[$];   // body words the core still has to hand over
  req_t        req_q[$];     // requests waiting to be raised
  logic [16:0] rx_in_q[$];   // flits to feed from the router, one per cycle
  rx_exp_t     rx_exp_q[$];  // expected rx outputs, one per cycle
  logic [16:0] obs_flit[$];  // flits seen on router_data_o
  int          obs_cyc[$];

  bit         req_pend = 0;
  logic [3:0] cur_dest = '0;
  logic [2:0] cur_len = '0;
  int body_rate = 100;
  int full_rate = 0;
  int full_hold = 0;
  int hold_after_ack = 0;
  bit rst_req = 0;
  bit full_at_edge = 0;
  bit chk_en = 0;
  int acks = 0;
  int reqs = 0;

  // receive reference: packet open flag, remaining bodies, source, error
  bit         m_open = 0;
  int         m_rem = 0;
  logic [3:0] m_src = '0;
  bit         m_err = 0;

  function automatic logic [16:0] mk(input logic [1:0] t, input logic [13:0] p);
    logic [16:0] f;
    f = {1'b1, t, p};
    return f;
  endfunction

  // Header seen by the router for this node (src fixed at 2).
  function automatic logic [16:0] mk_head(input logic [3:0] dest, input logic [3:0] src,
                                          input logic [2:0] cnt);
    return mk(2'b01, {dest, src, cnt, 3'b000});
  endfunction

  task automatic rx_model(input logic [16:0] f, input bit r, output rx_exp_t e);
    bit tail;
    bit last;
    e = '0;
    last = 0;
    if (r) begin
      m_open = 0; m_rem = 0; m_src = '0; m_err = 0;
    end else if (!f[16]) begin
      e.src = m_src;
      e.err = m_err;
    end else if (f[15:14] == 2'b01) begin
      if (m_open) m_err = 1;
      m_src  = f[9:6];
      m_rem  = int'(f[5:3]);
      m_open = 1;
      e.valid = 1; e.head = 1; e.src = m_src; e.data = f[13:0]; e.err = m_err;
    end else begin
      tail = (f[15:14] == 2'b10);
      if (!m_open) begin
        m_err = 1;
        last  = tail;
      end else begin
        if (tail && m_rem != 1) m_err = 1;
        m_rem = m_rem - 1;
        last  = tail || (m_rem == 0);
        if (last) m_open = 0;
      end
      e.valid = 1; e.last = last; e.src = m_src; e.data = f[13:0]; e.err = m_err;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic queue_req(input logic [3:0] dest, input logic [2:0] len, input logic [13:0] base);
    int n;
    req_t r;
    n = (len == 3'd0) ? 1 : int'(len);
    r.dest = dest;
    r.len  = len;
    req_q.push_back(r);
    exp_q.push_back(mk_head(dest, 4'd2, 3'(n)));
    for (int i = 0; i < n; i++) begin
      words_q.push_back(base + 14'(i));
      exp_q.push_back(mk((i == n - 1) ? 2'b10 : 2'b00, base + 14'(i)));
    end
  endtask

  task automatic push_rx_pkt(input logic [3:0] src, input logic [2:0] cnt);
    rx_in_q.push_back(mk_head(4'($urandom_range(0, 15)), src, cnt));
    for (int i = 0; i < int'(cnt) - 1; i++) begin
      if ($urandom_range(0, 3) == 0) rx_in_q.push_back(17'h0);
      rx_in_q.push_back(mk(2'b00, 14'($urandom_range(0, 16383))));
    end
    rx_in_q.push_back(mk(2'b10, 14'($urandom_range(0, 16383))));
  endtask

  // One clock: drive just after the falling edge, sample just before the
  // rising edge, return just after the next falling edge.
  task automatic cycle();
    logic [16:0] f;
    rx_exp_t e;
    req_t r;
    #2;
    if (!req_pend && req_q.size() > 0) begin
      r = req_q.pop_front();
      cur_dest = r.dest;
      cur_len  = r.len;
      req_pend = 1;
      reqs++;
    end
    nif.tx_req_i  = req_pend;
    nif.tx_dest_i = cur_dest;
    nif.tx_len_i  = cur_len;
    nif.tx_body_valid_i = (words_q.size() > 0) && (int'($urandom_range(0, 99)) < body_rate);
    nif.tx_body_i = '0;
    if (nif.tx_body_valid_i) nif.tx_body_i = words_q[0];
    if (full_hold > 0) begin
      nif.router_full_i = 1'b1;
      full_hold--;
    end else begin
      nif.router_full_i = (int'($urandom_range(0, 99)) < full_rate);
    end
    f = 17'h0;
    if (rx_in_q.size() > 0) f = rx_in_q.pop_front();
    nif.router_data_i = f;
    rst = rst_req;
    rx_model(f, rst_req, e);
    #4;
    full_at_edge = nif.router_full_i;
    rx_exp_q.push_back(e);
    if (rst_req) begin
      exp_q.delete();
      words_q.delete();
      req_q.delete();
      req_pend = 0;
      full_hold = 0;
    end else begin
      if (nif.tx_ack_o) begin
        check("ack_pending", 32'(req_pend), 32'd1);
        req_pend = 0;
        acks++;
        if (hold_after_ack > 0) begin
          full_hold = hold_after_ack;
          hold_after_ack = 0;
        end
      end
      if (nif.tx_body_ready_o) begin
        check("ready_legal", 32'(nif.tx_body_valid_i && !nif.router_full_i), 32'd1);
        if (words_q.size() > 0) void'(words_q.pop_front());
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_req = 1;
    cycle();
    rst_req = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    rx_exp_t e;
    if (rx_exp_q.size() > 0) begin
      e = rx_exp_q.pop_front();
      if (chk_en) begin
        check("rx_out", 32'({nif.rx_valid_o, nif.rx_head_o, nif.rx_last_o, nif.rx_src_o,
                             nif.rx_data_o, nif.rx_err_o}), 32'(e));
      end
    end
    if (chk_en) begin
      if (nif.router_data_o[16]) begin
        obs_flit.push_back(nif.router_data_o);
        obs_cyc.push_back(cyc);
        check("flit_credit", 32'(full_at_edge), 32'd0);
        if (exp_q.size() == 0) check("flit_unexpected", 32'(nif.router_data_o), 32'd0);
        else check("flit", 32'(nif.router_data_o), 32'(exp_q.pop_front()));
      end else begin
        check("idle_flit", 32'(nif.router_data_o), 32'd0);
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    nif.tx_req_i = 0; nif.tx_dest_i = '0; nif.tx_len_i = '0;
    nif.tx_body_valid_i = 0; nif.tx_body_i = '0;
    nif.router_full_i = 0; nif.router_data_i = '0;

    @(negedge clk);
    #1;
    rst_req = 1;
    cycle();
    cycle();
    rst_req = 0;
    chk_en = 1;

    // reset state
    check("rst_router_data", 32'(nif.router_data_o), 32'd0);
    check("rst_ack", 32'(nif.tx_ack_o), 32'd0);
    check("rst_ready", 32'(nif.tx_body_ready_o), 32'd0);
    check("rst_rx", 32'({nif.rx_valid_o, nif.rx_head_o, nif.rx_last_o, nif.rx_src_o,
                         nif.rx_data_o, nif.rx_err_o}), 32'd0);
    check("rst_state", 32'(tx_state), 32'(IDLE));

    // basic packet: dest 5, len 3, bodies 1..3, words ready alongside request
    obs_flit.delete(); obs_cyc.delete(); acks = 0;
    queue_req(4'd5, 3'd3, 14'h0001);
    run_cycles(10);
    check("basic_count", 32'(obs_flit.size()), 32'd4);
    if (obs_flit.size() == 4) begin
      check("basic_head", 32'(obs_flit[0]), 32'h15498);
      check("basic_body1", 32'(obs_flit[1]), 32'h10001);
      check("basic_body2", 32'(obs_flit[2]), 32'h10002);
      check("basic_tail", 32'(obs_flit[3]), 32'h18003);
      check("basic_span", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);
    end
    check("basic_acks", 32'(acks), 32'd1);

    // router full for 4 cycles right after the header
    obs_flit.delete(); obs_cyc.delete();
    hold_after_ack = 4;
    queue_req(4'hA, 3'd5, 14'h0100);
    run_cycles(14);
    check("stall_count", 32'(obs_flit.size()), 32'd6);
    if (obs_flit.size() == 6) begin
      check("stall_head", 32'(obs_flit[0]), 32'h168A8);
      check("stall_gap", 32'(obs_cyc[1] - obs_cyc[0]), 32'd5);
      check("stall_burst", 32'(obs_cyc[5] - obs_cyc[1]), 32'd4);
      check("stall_tail", 32'(obs_flit[5]), 32'h18104);
    end

    // len 1 then back-to-back len 0 (treated as 1)
    obs_flit.delete(); obs_cyc.delete();
    queue_req(4'd9, 3'd1, 14'h2AAA);
    queue_req(4'd1, 3'd0, 14'h0155);
    run_cycles(12);
    check("short_count", 32'(obs_flit.size()), 32'd4);
    if (obs_flit.size() == 4) begin
      check("short_head", 32'(obs_flit[0]), 32'h16488);
      check("short_tail", 32'(obs_flit[1]), 32'h1AAAA);
      check("zero_head", 32'(obs_flit[2]), 32'h14488);
      check("zero_tail", 32'(obs_flit[3]), 32'h18155);
      check("b2b_gap", 32'(obs_cyc[2] - obs_cyc[1]), 32'd2);
    end

    // reset in the middle of a long packet
    queue_req(4'd3, 3'd7, 14'h0300);
    run_cycles(5);
    do_reset();
    check("midrst_router_data", 32'(nif.router_data_o), 32'd0);
    check("midrst_ack", 32'(nif.tx_ack_o), 32'd0);
    check("midrst_ready", 32'(nif.tx_body_ready_o), 32'd0);
    check("midrst_state", 32'(tx_state), 32'(IDLE));
    obs_flit.delete(); obs_cyc.delete();
    queue_req(4'd4, 3'd2, 14'h0011);
    run_cycles(8);
    check("postrst_count", 32'(obs_flit.size()), 32'd3);
    if (obs_flit.size() == 3) begin
      check("postrst_head", 32'(obs_flit[0]), 32'h15090);
      check("postrst_tail", 32'(obs_flit[2]), 32'h18012);
    end

    // randomized traffic in both directions
    acks = 0; reqs = 0;
    full_rate = 25; body_rate = 70;
    for (int i = 0; i < 600; i++) begin
      if (req_q.size() == 0 && !req_pend && $urandom_range(0, 99) < 15)
        queue_req(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  14'($urandom_range(0, 16383)));
      if (rx_in_q.size() == 0 && $urandom_range(0, 99) < 30)
        push_rx_pkt(4'($urandom_range(0, 15)), 3'($urandom_range(1, 7)));
      cycle();
    end
    full_rate = 0; body_rate = 100;
    n = 0;
    while ((exp_q.size() > 0 || req_pend || req_q.size() > 0 || rx_in_q.size() > 0) && n < 400) begin
      cycle();
      n++;
    end
    run_cycles(2);
    check("drain_tx", 32'(exp_q.size()), 32'd0);
    check("drain_acks", 32'(acks), 32'(reqs));
    check("rand_rx_err", 32'(nif.rx_err_o), 32'd0);

    // well-formed receive: head(src 7, cnt 2), body, tail
    rx_in_q.push_back(mk_head(4'd2, 4'd7, 3'd2));
    rx_in_q.push_back(mk(2'b00, 14'h00AB));
    rx_in_q.push_back(mk(2'b10, 14'h00CD));
    cycle();
    check("rx_head_flag", 32'(nif.rx_head_o), 32'd1);
    check("rx_src", 32'(nif.rx_src_o), 32'd7);
    cycle();
    check("rx_mid_last", 32'(nif.rx_last_o), 32'd0);
    cycle();
    check("rx_last_flag", 32'(nif.rx_last_o), 32'd1);
    check("rx_tail_data", 32'(nif.rx_data_o), 32'h00CD);
    check("rx_clean_err", 32'(nif.rx_err_o), 32'd0);

    // orphan body sets a sticky error
    rx_in_q.push_back(mk(2'b00, 14'h0123));
    cycle();
    check("orphan_err", 32'(nif.rx_err_o), 32'd1);
    run_cycles(5);
    check("orphan_sticky", 32'(nif.rx_err_o), 32'd1);
    do_reset();
    check("err_cleared", 32'(nif.rx_err_o), 32'd0);

    // tail arriving too early
    rx_in_q.push_back(mk_head(4'd0, 4'd3, 3'd3));
    rx_in_q.push_back(mk(2'b10, 14'h0042));
    cycle();
    cycle();
    check("early_tail_err", 32'(nif.rx_err_o), 32'd1);
    check("early_tail_last", 32'(nif.rx_last_o), 32'd1);
    run_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
